// File: rtl/cpu_defs.sv
// Shared pipeline definitions for the LoongArch core.
// IF_ADEF_EN widens the IF->ID bus with an instruction-address-error flag.
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

`ifdef IF_ADEF_EN
  localparam int unsigned FS_TO_DS_BUS_WD = 65;
`else
  localparam int unsigned FS_TO_DS_BUS_WD = 64;
`endif

  localparam int unsigned BR_BUS_WD       = 33;
  localparam int unsigned DS_TO_ES_BUS_WD = 150;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

endpackage

// File: rtl/if_stage_if.sv
// IF-stage connections: IF->ID handshake, branch redirect from ID and the inst SRAM port.
interface if_stage_if;
  import cpu_defs::*;

  logic                       ds_allowin;
  logic [BR_BUS_WD-1:0]       br_bus;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       inst_sram_en;
  logic                       inst_sram_we;
  logic [31:0]                inst_sram_addr;
  logic [31:0]                inst_sram_wdata;
  logic [31:0]                inst_sram_rdata;

  modport master (
    input  ds_allowin, br_bus, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_we, inst_sram_addr,
           inst_sram_wdata
  );

  modport slave (
    output ds_allowin, br_bus, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_we, inst_sram_addr,
           inst_sram_wdata
  );

endinterface

// File: rtl/if_inst_buf.sv
// One-entry hold register for the SRAM word while ID stalls; the SRAM output is not
// stable once the read enable drops, so the word is captured on the first stall cycle.
module if_inst_buf (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fs_valid,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] rdata,
  output logic [31:0] fs_inst
);

  logic        buf_valid;
  logic [31:0] buf_inst;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      buf_inst  <= 32'h0;
    end else if (ds_allowin || br_taken) begin
      buf_valid <= 1'b0;
    end else if (fs_valid && !buf_valid) begin
      buf_valid <= 1'b1;
      buf_inst  <= rdata;
    end
  end

  assign fs_inst = buf_valid ? buf_inst : rdata;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the inst SRAM and hands {pc, inst} to ID.
// Optional IF_ADEF_EN flags misaligned fetches on the bus MSB and suppresses their SRAM read.
module if_stage
  import cpu_defs::*;
(
  input  logic      clk,
  input  logic      resetn,
  if_stage_if.master io
);

  br_bus_t     br;
  logic        to_fs_valid;
  logic        fs_valid;
  logic        fs_allowin;
  logic        fetch_go;
  logic        br_pend;
  logic [31:0] pend_target;
  logic [31:0] fs_pc;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic [31:0] buf_inst_out;

  assign br = br_bus_t'(io.br_bus);

  // Pre-IF becomes valid one cycle after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_fs_valid <= 1'b0;
    end else begin
      to_fs_valid <= 1'b1;
    end
  end

  assign seq_pc     = fs_pc + 32'd4;
  assign nextpc     = br.taken ? br.target : (br_pend ? pend_target : seq_pc);
  assign fs_allowin = ~fs_valid | io.ds_allowin;
  assign fetch_go   = to_fs_valid & fs_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_valid    <= 1'b0;
      fs_pc       <= RESET_PC - 32'd4;
      br_pend     <= 1'b0;
      pend_target <= 32'h0;
    end else begin
      if (fs_allowin) begin
        fs_valid <= to_fs_valid;
      end else if (br.taken) begin
        // Stalled instruction is cancelled; it must not surface once br_taken drops.
        fs_valid <= 1'b0;
      end
      if (fetch_go) begin
        fs_pc <= nextpc;
      end
      if (br.taken && !fetch_go) begin
        br_pend     <= 1'b1;
        pend_target <= br.target;
      end else if (fetch_go) begin
        br_pend <= 1'b0;
      end
    end
  end

  if_inst_buf u_inst_buf (
    .clk        (clk),
    .resetn     (resetn),
    .fs_valid   (fs_valid),
    .ds_allowin (io.ds_allowin),
    .br_taken   (br.taken),
    .rdata      (io.inst_sram_rdata),
    .fs_inst    (buf_inst_out)
  );

  assign io.fs_to_ds_valid  = fs_valid & ~br.taken;
  assign io.inst_sram_we    = 1'b0;
  assign io.inst_sram_wdata = 32'h0;
  assign io.inst_sram_addr  = nextpc;

`ifdef IF_ADEF_EN
  logic fs_adef;
  assign fs_adef          = |fs_pc[1:0];
  assign io.inst_sram_en  = fetch_go & ~(|nextpc[1:0]);
  assign io.fs_to_ds_bus  = {fs_adef, fs_pc, (fs_adef ? 32'h0 : buf_inst_out)};
`else
  assign io.inst_sram_en  = fetch_go;
  assign io.fs_to_ds_bus  = {fs_pc, buf_inst_out};
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: cycle table from reset release plus a fetch/deliver scoreboard.
module tb_if_stage;
  import cpu_defs::*;

  localparam logic [31:0] SALT = 32'h5a5a_c3c3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  if_stage_if sif ();

  if_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .io     (sif.master)
  );

  // SRAM model: word = addr ^ SALT one cycle after an enabled read; garbage otherwise.
  always @(posedge clk) begin
    if (sif.inst_sram_en) sif.inst_sram_rdata <= sif.inst_sram_addr ^ SALT;
    else                  sif.inst_sram_rdata <= $urandom;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] bus_pc, bus_inst;
  assign bus_pc   = sif.fs_to_ds_bus[63:32];
  assign bus_inst = sif.fs_to_ds_bus[31:0];

  // Scoreboard: fetched addresses queued, delivered words compared, cancelled ones dropped.
  logic [31:0] sb_q[$];
  logic        sb_on = 1'b0;
  logic [31:0] sb_exp;

  always @(negedge clk) begin
    if (resetn && sb_on) begin
      if (sif.fs_to_ds_valid && sif.ds_allowin) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_delivery", {33'h0, bus_pc}, 65'h1_ffff_ffff);
        end else begin
          sb_exp = sb_q.pop_front();
          check("sb_pc", {33'h0, bus_pc}, {33'h0, sb_exp});
          check("sb_inst", {33'h0, bus_inst}, {33'h0, sb_exp ^ SALT});
        end
      end else if (sif.br_bus[32] && sb_q.size() != 0) begin
        void'(sb_q.pop_front());
      end
      if (sif.inst_sram_en) sb_q.push_back(sif.inst_sram_addr);
    end
  end

  typedef struct {
    logic        ds;
    logic        br;
    logic [31:0] tgt;
    logic        ev;
    logic        een;
    logic [31:0] eaddr;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[26];
  bit   found;

  task automatic drive(input logic ds, input logic br, input logic [31:0] tgt);
    sif.ds_allowin = ds;
    sif.br_bus     = {br, tgt};
  endtask

  initial begin
    // Row 0 is the cycle in which resetn is released.
    tbl[0]  = '{1, 0, 0,            0, 0, 32'h1c00_0000, 0};
    tbl[1]  = '{1, 0, 0,            0, 1, 32'h1c00_0000, 0};
    tbl[2]  = '{1, 0, 0,            1, 1, 32'h1c00_0004, 32'h1c00_0000};
    tbl[3]  = '{1, 0, 0,            1, 1, 32'h1c00_0008, 32'h1c00_0004};
    tbl[4]  = '{0, 0, 0,            1, 0, 32'h1c00_000c, 32'h1c00_0008};
    tbl[5]  = '{0, 0, 0,            1, 0, 32'h1c00_000c, 32'h1c00_0008};
    tbl[6]  = '{0, 0, 0,            1, 0, 32'h1c00_000c, 32'h1c00_0008};
    tbl[7]  = '{1, 0, 0,            1, 1, 32'h1c00_000c, 32'h1c00_0008};
    tbl[8]  = '{1, 0, 0,            1, 1, 32'h1c00_0010, 32'h1c00_000c};
    tbl[9]  = '{1, 1, 32'h1c00_0100, 0, 1, 32'h1c00_0100, 0};
    tbl[10] = '{1, 0, 0,            1, 1, 32'h1c00_0104, 32'h1c00_0100};
    tbl[11] = '{0, 0, 0,            1, 0, 32'h1c00_0108, 32'h1c00_0104};
    tbl[12] = '{0, 1, 32'h1c00_0200, 0, 0, 32'h1c00_0200, 0};
    tbl[13] = '{0, 0, 0,            0, 1, 32'h1c00_0200, 0};
    tbl[14] = '{0, 0, 0,            1, 0, 32'h1c00_0204, 32'h1c00_0200};
    tbl[15] = '{0, 0, 0,            1, 0, 32'h1c00_0204, 32'h1c00_0200};
    tbl[16] = '{1, 0, 0,            1, 1, 32'h1c00_0204, 32'h1c00_0200};
    tbl[17] = '{1, 0, 0,            1, 1, 32'h1c00_0208, 32'h1c00_0204};
    tbl[18] = '{1, 1, 32'hffff_fffc, 0, 1, 32'hffff_fffc, 0};
    tbl[19] = '{1, 0, 0,            1, 1, 32'h0000_0000, 32'hffff_fffc};
    tbl[20] = '{1, 0, 0,            1, 1, 32'h0000_0004, 32'h0000_0000};
    tbl[21] = '{0, 0, 0,            1, 0, 32'h0000_0008, 32'h0000_0004};
    tbl[22] = '{0, 1, 32'h1c00_0300, 0, 0, 32'h1c00_0300, 0};
    tbl[23] = '{0, 1, 32'h1c00_0400, 0, 1, 32'h1c00_0400, 0};
    tbl[24] = '{1, 0, 0,            1, 1, 32'h1c00_0404, 32'h1c00_0400};
    tbl[25] = '{1, 0, 0,            1, 1, 32'h1c00_0408, 32'h1c00_0404};

    drive(1'b1, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {64'h0, sif.fs_to_ds_valid}, 65'h0);
    check("rst_en",    {64'h0, sif.inst_sram_en},   65'h0);
    check("rst_we",    {64'h0, sif.inst_sram_we},   65'h0);
    check("rst_wdata", {33'h0, sif.inst_sram_wdata}, 65'h0);

    for (int i = 0; i < 26; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        resetn = 1'b1;
        sb_on  = 1'b1;
      end
      drive(tbl[i].ds, tbl[i].br, tbl[i].tgt);
      @(negedge clk);
      check($sformatf("row%0d_valid", i), {64'h0, sif.fs_to_ds_valid}, {64'h0, tbl[i].ev});
      check($sformatf("row%0d_en", i),    {64'h0, sif.inst_sram_en},   {64'h0, tbl[i].een});
      check($sformatf("row%0d_addr", i),  {33'h0, sif.inst_sram_addr}, {33'h0, tbl[i].eaddr});
      if (tbl[i].ev) begin
        check($sformatf("row%0d_pc", i),   {33'h0, bus_pc},   {33'h0, tbl[i].epc});
        check($sformatf("row%0d_inst", i), {33'h0, bus_inst}, {33'h0, tbl[i].epc ^ SALT});
`ifdef IF_ADEF_EN
        check($sformatf("row%0d_adef", i), {64'h0, sif.fs_to_ds_bus[64]}, 65'h0);
`endif
      end
    end

    // Random stalls and aligned branches; scoreboard checks every delivery.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            32'h1c00_0000 | (32'($urandom_range(0, 255)) << 2));
    end
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 32'h0);
    repeat (4) @(posedge clk);

    // Asynchronous reset mid-stream, then restart from RESET_PC.
    #3;
    resetn = 1'b0;
    #1;
    check("midrst_valid", {64'h0, sif.fs_to_ds_valid}, 65'h0);
    check("midrst_en",    {64'h0, sif.inst_sram_en},   65'h0);
    sb_on = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    sb_on  = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (sif.inst_sram_en) begin
        found = 1'b1;
        check("midrst_first_addr", {33'h0, sif.inst_sram_addr}, {33'h0, RESET_PC});
      end
    end
    if (!found) check("midrst_en_timeout", 65'h0, 65'h1);
    repeat (6) @(posedge clk);

`ifdef IF_ADEF_EN
    sb_on = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 32'h1c00_0102);
    @(negedge clk);
    check("adef_en_off", {64'h0, sif.inst_sram_en},   65'h0);
    check("adef_addr",   {33'h0, sif.inst_sram_addr}, {33'h0, 32'h1c00_0102});
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("adef_valid", {64'h0, sif.fs_to_ds_valid},    65'h1);
    check("adef_flag",  {64'h0, sif.fs_to_ds_bus[64]},  65'h1);
    check("adef_pc",    {33'h0, bus_pc},   {33'h0, 32'h1c00_0102});
    check("adef_inst",  {33'h0, bus_inst}, 65'h0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 32'h1c00_0000);
    sb_q.delete();
    sb_on = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 32'h0);
    repeat (6) @(posedge clk);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
